// File: rtl/jump_target_unit_pkg.sv
// jump_target_unit_pkg: op encodings and constants shared by the jump target unit files.
package jump_target_unit_pkg;
  typedef enum logic [2:0] {
    JTU_OP_J    = 3'd0,
    JTU_OP_JAL  = 3'd1,
    JTU_OP_BR   = 3'd2,
    JTU_OP_JR   = 3'd3,
    JTU_OP_JALR = 3'd4
  } jtu_op_e;
  localparam int LINK_OFFSET = 8;
endpackage

// File: rtl/jump_target_unit_ras_stack.sv
// ras_stack: circular return-address stack; push when full overwrites the oldest entry.
//   clk, rst_n      clock, synchronous active-low reset (clears pointer and count)
//   push, push_data store push_data on top
//   pop             drop the top entry (ignored when empty)
//   top, nonempty   current top entry and whether it is valid
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            nonempty
);
  localparam int PW = $clog2(RAS_DEPTH);
  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q;
  logic [PW:0]     cnt_q;
  // ptr_q is the next free slot, so the top lives one below it
  assign top      = mem_q[PW'(ptr_q - PW'(1))];
  assign nonempty = cnt_q != '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push) begin
      mem_q[ptr_q] <= push_data;
      ptr_q        <= ptr_q + PW'(1);
      cnt_q        <= cnt_q == (PW+1)'(RAS_DEPTH) ? cnt_q : cnt_q + (PW+1)'(1);
    end else if (pop && nonempty) begin
      ptr_q <= ptr_q - PW'(1);
      cnt_q <= cnt_q - (PW+1)'(1);
    end
  end
endmodule

// File: rtl/jump_target_unit.sv
// jump_target_unit: registered J/JAL/BR/JR/JALR target, link and misalign generator with valid/ready output.
//   clk, rst_n                 clock, synchronous active-low reset
//   flush                      drop held result, blocks capture
//   in_valid/in_ready          request handshake
//   op, pc, instr_index, imm,  request fields
//   br_taken, rs_val, rs_is_ra
//   out_valid/out_ready        result handshake
//   redirect, target, link_addr, misalign, pred_valid, pred_target  registered results
//   Optional RAS prediction enabled by defining JTU_RAS_EN.
module jump_target_unit
  import jump_target_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int IDX_W     = 26,
  parameter int IMM_W     = 16,
  parameter int ALIGN     = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  pc,
  input  logic [IDX_W-1:0] instr_index,
  input  logic [IMM_W-1:0] imm,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  rs_val,
  input  logic             rs_is_ra,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             redirect,
  output logic [XLEN-1:0]  target,
  output logic [XLEN-1:0]  link_addr,
  output logic             misalign,
  output logic             pred_valid,
  output logic [XLEN-1:0]  pred_target
);
  logic            out_valid_q, redirect_q, misalign_q, pred_valid_q;
  logic [XLEN-1:0] target_q, link_q, pred_target_q;
  logic            redirect_d, misalign_d, pred_valid_d;
  logic [XLEN-1:0] target_d, link_d, pred_target_d;
  logic [XLEN-1:0] pc4, j_tgt, br_tgt;
  logic            cap, is_j, is_br, is_r, is_link;
  assign in_ready = !out_valid_q || out_ready;
  assign cap      = in_valid && in_ready && !flush;
  assign is_j     = op == JTU_OP_J || op == JTU_OP_JAL;
  assign is_br    = op == JTU_OP_BR;
  assign is_r     = op == JTU_OP_JR || op == JTU_OP_JALR;
  assign is_link  = op == JTU_OP_JAL || op == JTU_OP_JALR;
  assign pc4      = pc + XLEN'(4);
  assign j_tgt    = {pc4[XLEN-1 -: XLEN-IDX_W-ALIGN], instr_index, {ALIGN{1'b0}}};
  assign br_tgt   = pc4 + ({{(XLEN-IMM_W){imm[IMM_W-1]}}, imm} << ALIGN);
  always_comb begin
    target_d   = is_j ? j_tgt : is_r ? rs_val : (is_br && br_taken) ? br_tgt : pc4;
    redirect_d = is_j || is_r || (is_br && br_taken);
    link_d     = is_link ? pc + XLEN'(LINK_OFFSET) : '0;
    misalign_d = is_r && |rs_val[ALIGN-1:0];
  end
`ifdef JTU_RAS_EN
  logic            ras_push, ras_pop, ras_nonempty;
  logic [XLEN-1:0] ras_top;
  assign ras_push = cap && is_link;
  assign ras_pop  = cap && op == JTU_OP_JR && rs_is_ra;
  ras_stack #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (link_d),
    .top       (ras_top),
    .nonempty  (ras_nonempty)
  );
  assign pred_valid_d  = ras_pop && ras_nonempty;
  assign pred_target_d = pred_valid_d ? ras_top : '0;
`else
  assign pred_valid_d  = 1'b0;
  assign pred_target_d = '0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      redirect_q    <= 1'b0;
      target_q      <= '0;
      link_q        <= '0;
      misalign_q    <= 1'b0;
      pred_valid_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      out_valid_q <= cap || (out_valid_q && !out_ready && !flush);
      if (cap) begin
        redirect_q    <= redirect_d;
        target_q      <= target_d;
        link_q        <= link_d;
        misalign_q    <= misalign_d;
        pred_valid_q  <= pred_valid_d;
        pred_target_q <= pred_target_d;
      end
    end
  end
  assign out_valid   = out_valid_q;
  assign redirect    = redirect_q;
  assign target      = target_q;
  assign link_addr   = link_q;
  assign misalign    = misalign_q;
  assign pred_valid  = pred_valid_q;
  assign pred_target = pred_target_q;
endmodule
